// File: rtl/ux607_qspi_icb_arb_pkg.sv
// Shared definitions for the two-requester QSPI ICB arbiter:
// FSM state encoding and the response wait-counter width.
package ux607_qspi_icb_arb_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_RSP = 1'b1
  } arb_state_e;

  localparam int unsigned WCNT_W = 16;
  localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

endpackage

// File: rtl/ux607_qspi_icb_arb.sv
// Two-to-one ICB arbiter in front of the QSPI slave; one outstanding transaction,
// round-robin on contention, sticky response-timeout flag.
//   state       | meaning
//   ST_IDLE     | route selected requester's command to the slave
//   ST_WAIT_RSP | command accepted, route slave response to owner
module ux607_qspi_icb_arb
  import ux607_qspi_icb_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TMO_CYC = 4096
) (
  input  logic          clock,
  input  logic          reset,

  input  logic          m0_icb_cmd_valid,
  output logic          m0_icb_cmd_ready,
  input  logic [AW-1:0] m0_icb_cmd_addr,
  input  logic          m0_icb_cmd_read,
  input  logic [31:0]   m0_icb_cmd_wdata,
  output logic          m0_icb_rsp_valid,
  input  logic          m0_icb_rsp_ready,
  output logic [31:0]   m0_icb_rsp_rdata,

  input  logic          m1_icb_cmd_valid,
  output logic          m1_icb_cmd_ready,
  input  logic [AW-1:0] m1_icb_cmd_addr,
  input  logic          m1_icb_cmd_read,
  input  logic [31:0]   m1_icb_cmd_wdata,
  output logic          m1_icb_rsp_valid,
  input  logic          m1_icb_rsp_ready,
  output logic [31:0]   m1_icb_rsp_rdata,

  output logic          s_icb_cmd_valid,
  input  logic          s_icb_cmd_ready,
  output logic [AW-1:0] s_icb_cmd_addr,
  output logic          s_icb_cmd_read,
  output logic [31:0]   s_icb_cmd_wdata,
  input  logic          s_icb_rsp_valid,
  output logic          s_icb_rsp_ready,
  input  logic [31:0]   s_icb_rsp_rdata,

  output logic          tmo_err,
  output logic          owner
);

  localparam logic [WCNT_W-1:0] TMO_LAST = WCNT_W'(TMO_CYC - 1);

  arb_state_e        state_q, state_d;
  logic              sel;
  logic              lock_q, lock_sel_q;
  logic              owner_q, rr_q;
  logic              tmo_q;
  logic [WCNT_W-1:0] wcnt_q, wcnt_inc;
  logic              cmd_hs, rsp_hs;

  // A stalled command keeps its grant until the slave takes it.
  always_comb begin
    if (lock_q)                                   sel = lock_sel_q;
    else if (m0_icb_cmd_valid && m1_icb_cmd_valid) sel = rr_q;
    else                                          sel = m1_icb_cmd_valid;
  end

  assign cmd_hs   = (state_q == ST_IDLE)     && s_icb_cmd_valid && s_icb_cmd_ready;
  assign rsp_hs   = (state_q == ST_WAIT_RSP) && s_icb_rsp_valid && s_icb_rsp_ready;
  assign wcnt_inc = (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (cmd_hs) state_d = ST_WAIT_RSP;
      ST_WAIT_RSP: if (rsp_hs) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_icb_cmd_valid  = 1'b0;
    m0_icb_cmd_ready = 1'b0;
    m1_icb_cmd_ready = 1'b0;
    m0_icb_rsp_valid = 1'b0;
    m1_icb_rsp_valid = 1'b0;
    s_icb_rsp_ready  = 1'b0;
    s_icb_cmd_addr   = sel ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    s_icb_cmd_read   = sel ? m1_icb_cmd_read  : m0_icb_cmd_read;
    s_icb_cmd_wdata  = sel ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    case (state_q)
      ST_IDLE: begin
        s_icb_cmd_valid  = sel ? m1_icb_cmd_valid : m0_icb_cmd_valid;
        m0_icb_cmd_ready = ~sel & s_icb_cmd_ready;
        m1_icb_cmd_ready =  sel & s_icb_cmd_ready;
      end
      ST_WAIT_RSP: begin
        m0_icb_rsp_valid = ~owner_q & s_icb_rsp_valid;
        m1_icb_rsp_valid =  owner_q & s_icb_rsp_valid;
        s_icb_rsp_ready  = owner_q ? m1_icb_rsp_ready : m0_icb_rsp_ready;
      end
      default: ;
    endcase
  end

  assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
  assign m1_icb_rsp_rdata = s_icb_rsp_rdata;
  assign owner            = owner_q;
  assign tmo_err          = tmo_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
      owner_q    <= 1'b0;
      rr_q       <= 1'b0;
      wcnt_q     <= '0;
      tmo_q      <= 1'b0;
    end else begin
      lock_q     <= (state_q == ST_IDLE) && s_icb_cmd_valid && !s_icb_cmd_ready;
      lock_sel_q <= sel;
      if (cmd_hs) begin
        owner_q <= sel;
        wcnt_q  <= '0;
      end
      if (rsp_hs) rr_q <= ~owner_q;
      // Flag is raised as the count lands on TMO_CYC-1; the FSM keeps waiting.
      if (state_q == ST_WAIT_RSP) begin
        wcnt_q <= wcnt_inc;
        if (wcnt_inc == TMO_LAST) tmo_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ux607_qspi_icb_arb.sv
// Bench for ux607_qspi_icb_arb: directed scenarios then random traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_ux607_qspi_icb_arb;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        v[2], rdf[2], rr_in[2];
  logic [31:0] a[2], wd[2];
  logic        cr[2], rv[2];
  logic [31:0] rdo[2];
  logic        s_cv, s_cr, s_rdflag, s_rv, s_rr, tmo, own;
  logic [31:0] s_a, s_wd, s_rdat;

  int checks = 0;
  int failures = 0;

  // model state
  bit busy, m_owner, m_rr, m_tmo, pend_v, pend_sel, auto_drop;
  bit e_sel, e_sv;
  int wcyc;
  int n;

  ux607_qspi_icb_arb #(.AW(32), .TMO_CYC(TMO)) dut (
    .clock(clk), .reset(rst),
    .m0_icb_cmd_valid(v[0]), .m0_icb_cmd_ready(cr[0]), .m0_icb_cmd_addr(a[0]),
    .m0_icb_cmd_read(rdf[0]), .m0_icb_cmd_wdata(wd[0]), .m0_icb_rsp_valid(rv[0]),
    .m0_icb_rsp_ready(rr_in[0]), .m0_icb_rsp_rdata(rdo[0]),
    .m1_icb_cmd_valid(v[1]), .m1_icb_cmd_ready(cr[1]), .m1_icb_cmd_addr(a[1]),
    .m1_icb_cmd_read(rdf[1]), .m1_icb_cmd_wdata(wd[1]), .m1_icb_rsp_valid(rv[1]),
    .m1_icb_rsp_ready(rr_in[1]), .m1_icb_rsp_rdata(rdo[1]),
    .s_icb_cmd_valid(s_cv), .s_icb_cmd_ready(s_cr), .s_icb_cmd_addr(s_a),
    .s_icb_cmd_read(s_rdflag), .s_icb_cmd_wdata(s_wd), .s_icb_rsp_valid(s_rv),
    .s_icb_rsp_ready(s_rr), .s_icb_rsp_rdata(s_rdat),
    .tmo_err(tmo), .owner(own)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Let combinational outputs settle, then compare them with the model.
  task automatic settle();
    #2;
    e_sel = pend_v ? pend_sel : ((v[0] && v[1]) ? m_rr : v[1]);
    e_sv  = !busy && v[e_sel];
    chk("tmo_err", tmo, m_tmo);
    if (!busy) begin
      chk("idle_s_cmd_valid", s_cv, e_sv);
      chk("idle_cmd_ready0", cr[0], (e_sel == 1'b0) && s_cr);
      chk("idle_cmd_ready1", cr[1], (e_sel == 1'b1) && s_cr);
      chk("idle_s_rsp_ready", s_rr, 0);
      chk("idle_rsp_valid0", rv[0], 0);
      chk("idle_rsp_valid1", rv[1], 0);
      if (e_sv) begin
        chk("idle_s_addr", s_a, a[e_sel]);
        chk("idle_s_read", s_rdflag, rdf[e_sel]);
        chk("idle_s_wdata", s_wd, wd[e_sel]);
      end
    end else begin
      chk("wait_s_cmd_valid", s_cv, 0);
      chk("wait_cmd_ready0", cr[0], 0);
      chk("wait_cmd_ready1", cr[1], 0);
      chk("wait_owner", own, m_owner);
      chk("wait_rsp_valid_owner", rv[m_owner], s_rv);
      chk("wait_rsp_valid_other", rv[!m_owner], 0);
      chk("wait_s_rsp_ready", s_rr, rr_in[m_owner]);
      chk("wait_rdata0", rdo[0], s_rdat);
      chk("wait_rdata1", rdo[1], s_rdat);
    end
  endtask

  // Clock edge, then advance the model from the inputs that were presented.
  task automatic adv();
    @(posedge clk);
    #1;
    if (!busy) begin
      if (e_sv && s_cr) begin
        busy = 1; m_owner = e_sel; wcyc = 0; pend_v = 0;
        if (auto_drop) v[e_sel] = 1'b0;
      end else begin
        pend_v = e_sv; pend_sel = e_sel;
      end
    end else begin
      wcyc++;
      if (wcyc >= TMO - 1) m_tmo = 1;
      if (s_rv && rr_in[m_owner]) begin
        busy = 0; m_rr = !m_owner;
      end
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    #1;
    chk("rst_tmo_err", tmo, 0);
    chk("rst_owner", own, 0);
    chk("rst_s_rsp_ready", s_rr, 0);
    chk("rst_rsp_valid0", rv[0], 0);
    chk("rst_rsp_valid1", rv[1], 0);
    chk("rst_s_cmd_valid", s_cv, v[0] | v[1]);
    busy = 0; m_owner = 0; m_rr = 0; m_tmo = 0; pend_v = 0; pend_sel = 0; wcyc = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic respond(input bit who);
    s_rv = 1'b1; rr_in[who] = 1'b1; s_rdat = $urandom;
    settle(); adv();
    s_rv = 1'b0; rr_in[who] = 1'b0;
  endtask

  initial begin
    bit exp_order[4];
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    for (int i = 0; i < 2; i++) begin
      v[i] = 0; rdf[i] = 0; rr_in[i] = 0; a[i] = 0; wd[i] = 0;
    end
    s_cr = 0; s_rv = 0; s_rdat = 0; auto_drop = 1;
    reset_dut();

    // single read from m0
    v[0] = 1; a[0] = 32'h0000_0100; rdf[0] = 1; wd[0] = 32'h1234_5678; s_cr = 1;
    settle(); chk("r25_cmd_ready0", cr[0], 1); adv();
    s_cr = 0;
    for (int i = 0; i < 3; i++) begin settle(); adv(); end
    s_rv = 1; s_rdat = 32'hDEAD_BEEF; rr_in[0] = 1;
    settle();
    chk("r25_rsp_valid0", rv[0], 1);
    chk("r25_rsp_rdata0", rdo[0], 32'hDEAD_BEEF);
    chk("r25_rsp_valid1", rv[1], 0);
    chk("r25_owner", own, 0);
    adv();
    s_rv = 0; rr_in[0] = 0;
    v[0] = 1; a[0] = 32'h0000_0200; v[1] = 1; a[1] = 32'h0000_0300;
    settle(); chk("r25_rr_next_is_m1", s_a, 32'h0000_0300);

    // both requesters valid every cycle
    v[0] = 0; v[1] = 0;
    reset_dut();
    auto_drop = 0;
    v[0] = 1; v[1] = 1; a[0] = 32'hA0; a[1] = 32'hA1; s_cr = 1;
    for (int t = 0; t < 4; t++) begin
      settle();
      chk("r26_grant_ready", cr[exp_order[t]], 1);
      chk("r26_other_ready", cr[!exp_order[t]], 0);
      adv();
      settle(); chk("r26_owner", own, exp_order[t]); adv();
      respond(exp_order[t]);
    end
    auto_drop = 1; v[0] = 0; v[1] = 0; s_cr = 0;

    // stalled m1 keeps the grant after m0 arrives
    reset_dut();
    v[1] = 1; a[1] = 32'h111; s_cr = 0;
    for (int i = 0; i < 5; i++) begin settle(); adv(); end
    v[0] = 1; a[0] = 32'h222;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("r27_addr_held", s_a, 32'h111); adv();
    end
    s_cr = 1;
    settle(); chk("r27_ready1", cr[1], 1); chk("r27_ready0", cr[0], 0); adv();
    respond(1'b1);

    // response stalled by m0 rsp_ready=0
    settle(); chk("r30_m0_ready", cr[0], 1); adv();
    s_cr = 0; s_rv = 1; rr_in[0] = 0;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("r30_s_rsp_ready", s_rr, 0); chk("r30_in_wait", s_cv, 0); adv();
    end
    rr_in[0] = 1;
    settle(); chk("r30_s_rsp_ready_hs", s_rr, 1); adv();
    s_rv = 0; rr_in[0] = 0; v[1] = 1;
    settle(); chk("r30_back_idle", s_cv, 1); v[1] = 0;

    // timeout without a response
    reset_dut();
    v[0] = 1; s_cr = 1;
    settle(); adv();
    s_cr = 0;
    n = 0;
    while (n < 40) begin
      n++;
      settle();
      if (tmo === 1'b1) break;
      adv();
    end
    chk("r28_tmo_cycle", n, 8);
    s_rv = 1; rr_in[0] = 1;
    settle(); chk("r28_rsp_valid0", rv[0], 1); adv();
    s_rv = 0; rr_in[0] = 0; v[1] = 1;
    settle(); chk("r28_tmo_sticky", tmo, 1); chk("r28_idle", s_cv, 1);

    // reset in WAIT_RSP, then a late response
    s_cr = 1;
    settle(); adv();
    s_cr = 0;
    settle(); adv();
    s_rv = 1;
    reset_dut();
    settle();
    chk("r29_s_rsp_ready", s_rr, 0);
    chk("r29_rsp_valid0", rv[0], 0);
    chk("r29_rsp_valid1", rv[1], 0);
    adv();
    s_rv = 0;

    // random traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1; a[i] = $urandom; rdf[i] = 1'($urandom_range(0, 1)); wd[i] = $urandom;
        end
        rr_in[i] = 1'($urandom_range(0, 1));
      end
      s_cr = 1'($urandom_range(0, 1));
      s_rv = 1'($urandom_range(0, 1));
      s_rdat = $urandom;
      settle();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
